hex_cmd_parser: RTL and testbench

Downstream consumer of the receive FIFO. Drains bytes from the FIFO head, parses ASCII lines of the form two hex digits + LF (optional CR), and presents each decoded byte on a valid/ready output, e.g. to the LED register or a later command decoder. Malformed lines raise an error pulse, increment a saturating counter, and are discarded up to the next LF.

---
 rtl/hex_cmd_pkg.sv | 16 +
 rtl/hex_nibble_decode.sv | 21 ++
 rtl/hex_cmd_parser.sv | 123 ++++++++++++
 tb/tb_hex_cmd_parser.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_cmd_pkg.sv
// Shared types and character constants for the ASCII hex command parser.
package hex_cmd_pkg;

  typedef enum logic [2:0] {
    S_HI   = 3'd0,
    S_LO   = 3'd1,
    S_TERM = 3'd2,
    S_OUT  = 3'd3,
    S_SYNC = 3'd4
  } state_t;

  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_SP = 8'h20;

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder: flags 0-9, A-F, a-f and returns the nibble value.
module hex_nibble_decode (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] value
);

  always_comb begin
    is_hex = 1'b0;
    value  = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      value  = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // Both letter ranges have 1..6 in the low nibble, so add 9 to land on 10..15.
      is_hex = 1'b1;
      value  = ch[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/hex_cmd_parser.sv
// Drains a FWFT FIFO, parses "HH\n" lines (CR ignored) and presents each decoded byte on
// a valid/ready port; malformed lines pulse o_err and bump a saturating counter.
module hex_cmd_parser
  import hex_cmd_pkg::*;
#(
  parameter logic [7:0] P_TERM = C_LF,
  parameter logic [7:0] P_SKIP = C_CR
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_empty_n,
  input  logic [7:0] i_data,
  output logic       o_rd,
  output logic       o_valid,
  output logic [7:0] o_byte,
  input  logic       i_ready,
  output logic       o_err,
  output logic [7:0] o_err_cnt
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] hi_nib;
  logic [3:0] lo_nib;
  logic       is_hex;
  logic [3:0] nib_val;
  logic       rd;
  logic       err_now;
  logic       ld_hi;
  logic       ld_lo;
  logic       ld_out;

  hex_nibble_decode u_decode (
    .ch     (i_data),
    .is_hex (is_hex),
    .value  (nib_val)
  );

  // Handshakes: a FIFO byte is consumed on any edge with o_rd=1 (i_data valid while
  // i_empty_n); a decoded byte transfers on the edge with o_valid && i_ready, and
  // o_byte is held stable for as long as o_valid waits for i_ready.
  assign rd   = i_empty_n && (state != S_OUT);
  assign o_rd = rd;

  always_comb begin
    state_nxt = state;
    err_now   = 1'b0;
    ld_hi     = 1'b0;
    ld_lo     = 1'b0;
    ld_out    = 1'b0;
    case (state)
      S_HI: begin
        if (rd) begin
          if (is_hex) begin
            ld_hi     = 1'b1;
            state_nxt = S_LO;
          end else if (!(i_data == P_SKIP || i_data == C_SP || i_data == P_TERM)) begin
            err_now   = 1'b1;
            state_nxt = S_SYNC;
          end
        end
      end
      S_LO: begin
        if (rd) begin
          if (is_hex) begin
            ld_lo     = 1'b1;
            state_nxt = S_TERM;
          end else if (i_data == P_TERM) begin
            // Line already ended, so no resync is needed.
            err_now   = 1'b1;
            state_nxt = S_HI;
          end else if (i_data != P_SKIP) begin
            err_now   = 1'b1;
            state_nxt = S_SYNC;
          end
        end
      end
      S_TERM: begin
        if (rd) begin
          if (i_data == P_TERM) begin
            ld_out    = 1'b1;
            state_nxt = S_OUT;
          end else if (i_data != P_SKIP) begin
            err_now   = 1'b1;
            state_nxt = S_SYNC;
          end
        end
      end
      S_OUT: begin
        if (i_ready) state_nxt = S_HI;
      end
      S_SYNC: begin
        if (rd && i_data == P_TERM) state_nxt = S_HI;
      end
      default: state_nxt = S_HI;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_HI;
      hi_nib    <= 4'h0;
      lo_nib    <= 4'h0;
      o_valid   <= 1'b0;
      o_byte    <= 8'h00;
      o_err     <= 1'b0;
      o_err_cnt <= 8'h00;
    end else begin
      state <= state_nxt;
      o_err <= err_now;
      if (err_now && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      if (ld_hi) hi_nib <= nib_val;
      if (ld_lo) lo_nib <= nib_val;
      if (ld_out) begin
        o_byte  <= {hi_nib, lo_nib};
        o_valid <= 1'b1;
      end else if (state == S_OUT && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Directed bench for hex_cmd_parser: line-level reference model checked every cycle,
// plus a scoreboard of hand-written expected bytes and literal counter checks.
module tb_hex_cmd_parser;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_empty_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       o_rd;
  logic       o_valid;
  logic [7:0] o_byte;
  logic       i_ready = 1'b1;
  logic       o_err;
  logic [7:0] o_err_cnt;

  hex_cmd_parser dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_empty_n (i_empty_n),
    .i_data    (i_data),
    .o_rd      (o_rd),
    .o_valid   (o_valid),
    .o_byte    (o_byte),
    .i_ready   (i_ready),
    .o_err     (o_err),
    .o_err_cnt (o_err_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       rst_req = 1'b1;
  logic       armed = 1'b0;
  int         hold = 0;
  int         err_pulses = 0;
  int         stall_cycles = 0;

  // Reference model: counts hex digits of the current line rather than tracking parser states.
  logic       m_valid = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_err = 1'b0;
  int         m_cnt = 0;
  int         m_nhex = 0;
  logic [3:0] m_dig[2];
  logic       m_discard = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic logic [3:0] m_hex_val(input logic [7:0] c);
    int v;
    if (c <= "9") v = int'(c) - 48;
    else if (c <= "F") v = int'(c) - 55;
    else v = int'(c) - 87;
    return 4'(v);
  endfunction

  task automatic model_step(input logic rst, input logic rd, input logic [7:0] c, input logic rdy);
    logic e;
    e = 1'b0;
    if (rst) begin
      m_valid = 0; m_byte = 0; m_err = 0; m_cnt = 0; m_nhex = 0; m_discard = 0;
      return;
    end
    if (m_valid) begin
      if (rdy) m_valid = 1'b0;
    end else if (rd) begin
      if (m_discard) begin
        if (c == 8'h0A) m_discard = 1'b0;
      end else if (c == 8'h0A) begin
        if (m_nhex == 2) begin
          m_byte  = {m_dig[0], m_dig[1]};
          m_valid = 1'b1;
        end else if (m_nhex == 1) begin
          e = 1'b1;
        end
        m_nhex = 0;
      end else if (c == 8'h0D) begin
        // carriage return is transparent inside a line
      end else if (m_is_hex(c) && m_nhex < 2) begin
        m_dig[m_nhex] = m_hex_val(c);
        m_nhex++;
      end else if (c == 8'h20 && m_nhex == 0) begin
        // leading blanks are allowed
      end else begin
        e = 1'b1;
        m_discard = 1'b1;
        m_nhex = 0;
      end
    end
    m_err = e;
    if (e && m_cnt < 255) m_cnt++;
  endtask

  // One clock: compare at negedge, drive inputs, then advance model and FIFO for the next edge.
  task automatic step();
    logic rd_m;
    @(negedge clk);
    if (armed) begin
      chk("o_valid", int'(o_valid), int'(m_valid));
      chk("o_byte", int'(o_byte), int'(m_byte));
      chk("o_err", int'(o_err), int'(m_err));
      chk("o_err_cnt", int'(o_err_cnt), m_cnt);
      if (o_err) err_pulses++;
    end
    i_rst     = rst_req;
    i_empty_n = (fifo_q.size() != 0);
    i_data    = i_empty_n ? fifo_q[0] : 8'h00;
    i_ready   = (hold == 0);
    if (o_valid && hold > 0) hold--;
    if (o_valid && !i_ready) stall_cycles++;
    #1;
    rd_m = i_empty_n && !m_valid;
    if (armed) chk("o_rd", int'(o_rd), int'(rd_m));
    if (armed && o_valid && i_ready && !i_rst) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", int'(o_byte), 256);
      end else begin
        chk("sb_byte", int'(o_byte), int'(exp_q.pop_front()));
      end
    end
    if (o_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    model_step(i_rst, rd_m, i_data, i_ready);
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) fifo_q.push_back(s[i]);
  endtask

  task automatic run_idle();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || m_valid || o_valid) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("idle_timeout", n, 0);
    step();
    step();
  endtask

  task automatic scenario_end(input string name, input int pulses, input int cnt);
    chk({name, "_sb_drain"}, exp_q.size(), 0);
    chk({name, "_err_pulses"}, err_pulses, pulses);
    chk({name, "_err_cnt"}, int'(o_err_cnt), cnt);
    exp_q.delete();
    err_pulses = 0;
  endtask

  initial begin
    m_dig[0] = 4'h0;
    m_dig[1] = 4'h0;
    step();
    step();
    armed = 1'b1;
    rst_req = 1'b0;
    step();
    chk("reset_valid", int'(o_valid), 0);
    chk("reset_byte", int'(o_byte), 0);
    chk("reset_err_cnt", int'(o_err_cnt), 0);

    feed("A5\n");            exp_q.push_back(8'hA5);
    run_idle();              scenario_end("a5", 0, 0);

    feed("3c\r\n"); feed("\n"); exp_q.push_back(8'h3C);
    run_idle();              scenario_end("3c_empty", 0, 0);

    feed("G1\n01\n");        exp_q.push_back(8'h01);
    run_idle();              scenario_end("g1", 1, 1);

    feed("7\n"); feed("FF\n"); exp_q.push_back(8'hFF);
    run_idle();              scenario_end("short", 1, 2);

    feed(" 9b\r\n");         exp_q.push_back(8'h9B);
    feed("123\n");
    feed("e0\n");            exp_q.push_back(8'hE0);
    run_idle();              scenario_end("blank_third", 1, 3);

    hold = 10;
    stall_cycles = 0;
    feed("12\n34\n");        exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    run_idle();
    chk("stall_cycles", stall_cycles, 10);
    scenario_end("backpressure", 0, 3);

    feed("4");
    run_idle();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk("midreset_valid", int'(o_valid), 0);
    chk("midreset_byte", int'(o_byte), 0);
    chk("midreset_err", int'(o_err), 0);
    chk("midreset_err_cnt", int'(o_err_cnt), 0);
    feed("2F\n");            exp_q.push_back(8'h2F);
    run_idle();              scenario_end("after_reset", 0, 0);

    for (int i = 0; i < 260; i++) feed("Z\n");
    run_idle();              scenario_end("saturate", 260, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
